// File: rtl/lsu_pkg.sv
// Shared encodings for the sub-word load/store unit: access sizes, FSM states, lane geometry.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_RMW_READ = 2'd2,
    ST_WRITE    = 2'd3
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE3 = 2'd3;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Reserved size 2'b11 is classified with words.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      default: is_misaligned = (lane != LANE0);
    endcase
  endfunction

endpackage

// File: rtl/lsu_subword_if.sv
// Request/response bus between the MEM stage (master) and the load/store unit (slave).
interface lsu_subword_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: load extraction with sign/zero extension, and store merge into an old word.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic signed [BYTE_W-1:0] b, input logic zx);
    logic signed [DATA_W-1:0] sx;
    sx = DATA_W'(b);
    ext_byte = zx ? {{(DATA_W-BYTE_W){1'b0}}, b} : sx;
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic signed [HALF_W-1:0] h, input logic zx);
    logic signed [DATA_W-1:0] sx;
    sx = DATA_W'(h);
    ext_half = zx ? {{(DATA_W-HALF_W){1'b0}}, h} : sx;
  endfunction

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  assign byte_sel = old_word[{lane, 3'b000} +: BYTE_W];
  assign half_sel = old_word[{lane[1], 4'b0000} +: HALF_W];

  always_comb begin
    load_data  = old_word;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = ext_byte(byte_sel, uns);
        merge_data = old_word;
        merge_data[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      SZ_HALF: begin
        load_data  = ext_half(half_sel, uns);
        merge_data = old_word;
        merge_data[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// Byte/halfword load/store unit over a word-only data memory, with read-modify-write for sub-word stores.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_subword_if.slave      bus,
  output logic              dmem_memwrite,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data_in,
  input  logic [DATA_W-1:0] dmem_readdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              memwrite_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic              accept;
  logic              misaligned;

  assign accept = bus.req_valid && (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  lsu_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .size       (size_q),
    .uns        (uns_q),
    .lane       (addr_q[1:0]),
    .old_word   (dmem_readdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      memwrite_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            if (misaligned) begin
              // Trapped access: respond next cycle without touching memory.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!bus.req_we) begin
              state <= ST_LOAD;
            end else if (bus.req_size[1]) begin
              merge_q    <= bus.req_wdata;
              memwrite_q <= 1'b1;
              state      <= ST_WRITE;
            end else begin
              state <= ST_RMW_READ;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata_q <= load_data;
          resp_valid_q <= 1'b1;
          state        <= ST_IDLE;
        end
        ST_RMW_READ: begin
          merge_q    <= merge_data;
          memwrite_q <= 1'b1;
          state      <= ST_WRITE;
        end
        default: begin
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign dmem_memwrite  = memwrite_q;
  assign dmem_address   = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_data_in   = merge_q;

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the MEM pipeline stage and the word-only data memory.
- The data memory stores whole words only, with write-on-clock and combinational read.
- This block does byte and halfword access on top of it: lane extraction and sign/zero extension for loads, and a read-modify-write sequence for sub-word stores.
- One request outstanding at a time, valid/ready on the request side and a single-cycle response pulse.

Parameters:
- ADDR_W, 32, byte address width presented to the data memory.
- DATA_W, 32, data word width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- req_unsigned  in  1  loads only: zero-extend (LBU/LHU) when 1, sign-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse for load or store
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_err  out  1  misaligned access flag; constant 0 unless MISALIGN_TRAP_EN
- dmem_memwrite  out  1  data-memory write enable
- dmem_address  out  ADDR_W  data-memory address, low 2 bits forced 0
- dmem_data_in  out  DATA_W  data-memory write data
- dmem_readdata  in  DATA_W  data-memory combinational read data

Behaviour:
- Clock and reset: single clock domain, clk; rst_n is asynchronous active-low.
- Reset values:
  - state=IDLE
  - resp_valid=0, resp_rdata=0, resp_err=0
  - dmem_memwrite=0
  - latched address/data/size regs=0
  - req_ready=1 once rst_n is high.
- Memory ordering: little-endian.
  - Byte lane = addr[1:0]: lane0=bits[7:0], lane3=bits[31:24].
  - Half lane = addr[1]: 0 selects [15:0], 1 selects [31:16].
- Request accept: in IDLE when req_valid & req_ready. All request fields are latched at that edge.
- FSM states: IDLE, LOAD, RMW_READ, WRITE.
  - IDLE accept, load -> LOAD.
  - IDLE accept, word store -> WRITE. The merge reg gets req_wdata.
  - IDLE accept, byte/half store -> RMW_READ.
  - LOAD:
    - dmem_address=latched addr.
    - Extract the lane from dmem_readdata and extend it.
    - Register into resp_rdata; resp_valid=1 next cycle.
    - -> IDLE.
  - RMW_READ:
    - Capture dmem_readdata.
    - Replace the selected byte/half with the low bits of the latched wdata, other lanes unchanged.
    - Store the result in the merge reg.
    - -> WRITE.
  - WRITE:
    - dmem_memwrite=1; dmem_data_in=merge reg.
    - The write happens at the end of the cycle.
    - resp_valid=1 next cycle with resp_rdata=0.
    - -> IDLE.
- DMEM outputs outside WRITE: dmem_memwrite=0. dmem_address holds the last latched address.
- Latency (accept edge = cycle 0):
  - Load: resp_valid in cycle 2.
  - Word store: memory updated at end of cycle 1; resp_valid in cycle 2.
  - Sub-word store: memory updated at end of cycle 2; resp_valid in cycle 3.
- Back-to-back: the state is IDLE during the resp_valid cycle, so a new request may be accepted in that same cycle. A load directly after a store sees the stored data.
- Reserved size 11: behaves exactly as a word access.
- Misalignment without the macro: the low address bits below the access size are ignored.
- Reset mid-operation: state -> IDLE and dmem_memwrite drops immediately. A write whose clock edge has not occurred is lost. No resp_valid is issued for the abandoned request.
- req_valid dropped without handshake: ignored; no side effects.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - It is accepted, performs no DMEM read or write, and goes IDLE -> IDLE.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0. Latency 1.
- Undefined: resp_err is tied 0 and misaligned addresses are silently aligned as above.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding for IDLE/LOAD/RMW_READ/WRITE.
  - Lane-index constants.
- One sub-module, lsu_lane_unit: purely combinational.
  - Load path: extract plus sign/zero extend.
  - Store path: merge of write data into the old word.
  - Shared by the LOAD and RMW_READ paths; the FSM stays in lsu_subword.

Test Plan:
- Reset, then SW addr=0x8 wdata=0xDEADBEEF -> dmem_memwrite pulse in cycle 1 at dmem_address=0x8, resp_valid in cycle 2; LW 0x8 then returns 0xDEADBEEF.
- Memory 0x8=0xDEADBEEF:
  - LB 0x8 -> 0xFFFFFFEF.
  - LBU 0x9 -> 0x000000BE.
  - LH 0xA -> 0xFFFFDEAD.
  - LHU 0x8 -> 0x0000BEEF.
- SB 0xB wdata=0x12 onto 0xDEADBEEF -> memory 0x12ADBEEF, resp_valid in cycle 3. SH 0x8 wdata=0x5555 -> 0x12AD5555.
- Back-to-back: SB 0x4 then LW 0x4 issued the cycle resp_valid rises -> the load returns the merged word, no bubble beyond the FSM latency.
- Assert rst_n low during RMW_READ of SB 0xC -> dmem_memwrite never asserts, memory 0xC unchanged, resp_valid=0, req_ready=1 after release.
- With LSU_MISALIGN_TRAP_EN: LW 0x6 -> resp_err=1, resp_rdata=0, no dmem_memwrite, resp_valid in cycle 1. Without the macro: the same request reads word 0x4.
